// File: rtl/dlx_mem_access_ctrl_if.sv
// Control/address half of the DLX memory bus (mem_interface).
// The data lines are tristate and travel as a plain inout port beside this interface.
interface dlx_mem_access_ctrl_if #(
  parameter int ADDRESS_SIZE = 16
);
  logic [ADDRESS_SIZE-1:0] ADDRESS;
  logic                    ENABLE;
  logic                    READNOTWRITE;
  logic                    DATA_READY;

  modport master (
    output ADDRESS,
    output ENABLE,
    output READNOTWRITE,
    input  DATA_READY
  );

  modport slave (
    input  ADDRESS,
    input  ENABLE,
    input  READNOTWRITE,
    output DATA_READY
  );
endinterface

// File: rtl/dlx_mem_access_ctrl.sv
// Bus master between the DLX fetch/memory stage and a mem_interface slave.
// Turns a one-cycle CPU request into a four-phase ENABLE/DATA_READY transaction with timeout.
module dlx_mem_access_ctrl #(
  parameter int ADDRESS_SIZE   = 16,
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req_i,
  input  logic                    cpu_rnw_i,
  input  logic [ADDRESS_SIZE-1:0] cpu_addr_i,
  input  logic [WORD_SIZE-1:0]    cpu_wdata_i,
  output logic                    cpu_stall_o,
  output logic                    cpu_ack_o,
  output logic                    cpu_err_o,
  output logic [WORD_SIZE-1:0]    cpu_rdata_o,
  dlx_mem_access_ctrl_if.master   bus,
  inout  wire  [WORD_SIZE-1:0]    inout_data_io
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic                    rnw_q, rnw_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
  logic                    enable_q, enable_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rnw_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      enable_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rnw_q    <= rnw_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      enable_q <= enable_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rnw_d    = rnw_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    enable_d = enable_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          addr_d   = cpu_addr_i;
          rnw_d    = cpu_rnw_i;
          wdata_d  = cpu_wdata_i;
          enable_d = 1'b1;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        enable_d = 1'b1;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        // A response arriving on the last allowed cycle still counts as success.
        if (bus.DATA_READY) begin
          if (rnw_q) begin
            rdata_d = inout_data_io;
          end
          enable_d = 1'b0;
          ack_d    = 1'b1;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          enable_d = 1'b0;
          ack_d    = 1'b1;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (!bus.DATA_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_stall_o = ((state_q == IDLE) && cpu_req_i)
                     || (state_q == ACCESS)
                     || ((state_q == RESP) && !ack_q && cpu_req_i);

  assign cpu_ack_o   = ack_q;
  assign cpu_err_o   = err_q;
  assign cpu_rdata_o = rdata_q;

  assign bus.ADDRESS      = addr_q;
  assign bus.ENABLE       = enable_q;
  assign bus.READNOTWRITE = rnw_q;

  assign inout_data_io = ((state_q == ACCESS) && !rnw_q) ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: doc/dlx_mem_access_ctrl.md
Name: dlx_mem_access_ctrl

Overview:
- Synchronous master placed between the DLX fetch/memory stage and a memory slave on the mem_interface bus (ADDRESS, ENABLE, READNOTWRITE, INOUT_DATA, DATA_READY).
- Converts a single-cycle CPU request into an ENABLE/DATA_READY four-phase bus transaction.
- Stalls the pipeline while the transaction is in flight, returns read data with a one-cycle ack, and flags an error when the slave does not respond in time.

Parameters:
ADDRESS_SIZE, 16, bus address width
WORD_SIZE, 32, data word width
TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles to wait for DATA_READY (must be >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
cpu_req  input  1  request strobe, sampled only in IDLE
cpu_rnw  input  1  1=read, 0=write
cpu_addr  input  ADDRESS_SIZE  request address
cpu_wdata  input  WORD_SIZE  write data
cpu_stall  output  1  pipeline hold, combinational
cpu_ack  output  1  one-cycle completion pulse, registered
cpu_err  output  1  timeout flag, valid with cpu_ack
cpu_rdata  output  WORD_SIZE  captured read data, valid with cpu_ack on reads
ADDRESS  output  ADDRESS_SIZE  bus address, registered
ENABLE  output  1  bus request, registered
READNOTWRITE  output  1  bus direction, registered
INOUT_DATA  inout  WORD_SIZE  bidirectional bus data
DATA_READY  input  1  slave completion

Behaviour:
- Reset (rst=1 at a clk edge), from any state, including mid-transaction:
  - State goes to IDLE.
  - ENABLE, cpu_ack, cpu_err and the timeout counter clear to 0.
  - ADDRESS, cpu_rdata and READNOTWRITE reset to 0. READNOTWRITE=0 is harmless because ENABLE is 0.
  - INOUT_DATA is released to Z.
  - cpu_stall follows its combinational equation.
- IDLE:
  - If cpu_req=1, latch cpu_addr into ADDRESS, cpu_rnw into READNOTWRITE and cpu_wdata into an internal register.
  - Set ENABLE=1, clear the counter, go to ACCESS.
  - cpu_req=0 keeps the block in IDLE.
- ACCESS:
  - ENABLE is held at 1 and the counter increments each cycle.
  - INOUT_DATA is driven with the latched wdata only when READNOTWRITE=0; otherwise it is Z.
  - If DATA_READY=1: on a read, capture INOUT_DATA into cpu_rdata. Then ENABLE<=0, cpu_ack<=1, cpu_err<=0, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: ENABLE<=0, cpu_ack<=1, cpu_err<=1, go to RESP. cpu_rdata is unchanged.
  - DATA_READY takes priority over timeout when both occur in the same cycle.
- RESP:
  - cpu_ack=1 on the first RESP cycle only, then 0.
  - cpu_err holds its value until the next request is accepted.
  - Wait for DATA_READY=0 (four-phase return), then go to IDLE. If DATA_READY is already 0, RESP lasts 1 cycle.
  - cpu_req during RESP is not accepted. The CPU keeps it asserted and it is accepted in IDLE.
- cpu_stall = (IDLE & cpu_req) | ACCESS | (RESP & ~cpu_ack & cpu_req). It is 0 on the ack cycle.
- Latency: a slave asserting DATA_READY N cycles after ENABLE rises gives:
  - cpu_ack N+1 cycles after ENABLE rises;
  - cpu_ack N+2 cycles after cpu_req is sampled.
- Back-to-back: minimum issue rate is one transaction per 3 cycles (IDLE, ACCESS, RESP).
- Counter width is $clog2(TIMEOUT_CYCLES)+1. It saturates and never wraps in ACCESS.
- No X may propagate onto ENABLE/ADDRESS. A DATA_READY pulse in IDLE is ignored.

Test Plan:
- Read, slave latency 3 -> cpu_req at cycle 0 with addr=16'h0040. ENABLE high on cycles 1-4. Slave drives 32'hDEADBEEF with DATA_READY on cycle 4. Required: cpu_ack=1 on cycle 5 with cpu_rdata=32'hDEADBEEF, cpu_err=0, cpu_stall high on cycles 0-4 and low on cycle 5.
- Write addr=16'h0100, wdata=32'h12345678, latency 1 -> READNOTWRITE=0 and INOUT_DATA=32'h12345678 while ENABLE=1. Bus returns to Z after DATA_READY. Single cpu_ack, cpu_err=0.
- Silent slave with TIMEOUT_CYCLES=16 -> ENABLE high for exactly 16 cycles, then cpu_ack=1 with cpu_err=1. cpu_rdata keeps its previous value. Next request clears cpu_err.
- Slave holds DATA_READY 4 extra cycles and cpu_req stays high -> exactly one cpu_ack. Block stays in RESP with cpu_stall=1 until DATA_READY falls. The second request is accepted in IDLE and ENABLE re-asserts on the following cycle.
- rst=1 in the 2nd ACCESS cycle of a write -> next edge: ENABLE=0, INOUT_DATA=Z, cpu_ack=0, state IDLE. A late DATA_READY produces no ack.
- DATA_READY and timeout in the same cycle (slave latency 15) -> cpu_ack with cpu_err=0 and valid read data.
